// File: rtl/prog_sequencer.sv
// prog_sequencer: program counter sequencer with an IDLE/RUN/DONE controller,
// a small jump-target LUT, conditional absolute/relative jumps, registered
// ALU flags and a saturating RUN-cycle counter.
module prog_sequencer #(
  parameter int  D         = 12,   // program counter width
  parameter int  LUT_DEPTH = 4,    // jump-target LUT entries (power of two, >= 2)
  parameter int  OW        = 8,    // signed relative-offset width (OW <= D)
  parameter int  CW        = 16,   // cycle counter width
  parameter int  HALT_ADDR = 128,  // PC value that ends a run
  localparam int LW        = $clog2(LUT_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,       // asynchronous, active-low
  input  logic          req,
  input  logic          stall,
  input  logic          halt,
  input  logic          absjump_en,
  input  logic          reljump_en,
  input  logic [1:0]    cond_sel,
  input  logic [LW-1:0] lut_sel,
  input  logic [OW-1:0] rel_off,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  input  logic          zero_i,
  input  logic          pari_i,
  input  logic          sc_i,
  input  logic          flag_en,
  input  logic          sc_clr,
  input  logic          sc_en,
  output logic [D-1:0]  prog_ctr,
  output logic          zeroQ,
  output logic          pariQ,
  output logic          sc_q,
  output logic          run,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [D-1:0]  lut [LUT_DEPTH];
  logic          cond_ok;
  logic [D-1:0]  pc_target;
  logic          finish;

  // Status outputs are plain decodes of the state register.
  assign run  = (state == RUN);
  assign done = (state == DONE);

  // Jump condition, evaluated on the registered (pre-edge) flags.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    cond_ok = 1'b1;
    unique case (cond_sel)
      2'b00: cond_ok = 1'b1;
      2'b01: cond_ok = zeroQ;
      2'b10: cond_ok = ~zeroQ;
      2'b11: cond_ok = sc_q;
    endcase
  end

  // Next PC by priority: halt holds, absolute jump beats relative jump, else increment.
  always_comb begin
    pc_target = prog_ctr + D'(1);
    if (halt) begin
      pc_target = prog_ctr;
    end else if (absjump_en && cond_ok) begin
      // Combinational read sees the pre-edge LUT contents, so a same-cycle write returns the old entry.
      pc_target = lut[lut_sel];
    end else if (reljump_en && cond_ok) begin
      pc_target = prog_ctr + D'($signed(rel_off));
    end
  end

  // A run ends on an explicit halt or when the chosen next PC lands on HALT_ADDR.
  assign finish = halt || (pc_target == D'(HALT_ADDR));

  // Controller, program counter, cycle counter and flag registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      cycle_cnt <= '0;
      zeroQ     <= 1'b0;
      pariQ     <= 1'b0;
      sc_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= RUN;
            prog_ctr  <= '0;
            cycle_cnt <= '0;
          end
        end
        RUN: begin
          // Stalled cycles still count; the counter saturates at all-ones.
          if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CW'(1);
          end
          if (!stall) begin
            prog_ctr <= pc_target;
            if (finish) begin
              state <= DONE;
            end
            if (flag_en) begin
              zeroQ <= zero_i;
              pariQ <= pari_i;
            end
            if (sc_clr) begin
              sc_q <= 1'b0;
            end else if (sc_en) begin
              sc_q <= sc_i;
            end
          end
        end
        DONE: begin
          if (!req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Jump-target LUT, writable in every state.
  // NOTE: the LUT must read as zero straight after reset, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule
